// File: rtl/seq_share_pkg.sv
// Shared definitions for the sequence-sharing arbiter: the 14-entry value table,
// the FSM state type and a wrap-aware index helper.
package seq_share_pkg;

  localparam int SEQ_LEN = 14;

  localparam logic [3:0] SEQ_TABLE [0:SEQ_LEN-1] = '{
    4'd1, 4'd7, 4'd11, 4'd4, 4'd9, 4'd2, 4'd5,
    4'd12, 4'd6, 4'd3, 4'd15, 4'd8, 4'd14, 4'd13
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    PAUSED = 2'd2
  } state_t;

  function automatic logic [3:0] next_seq_idx(input logic [3:0] idx);
    return (idx == 4'(SEQ_LEN - 1)) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/seq_share_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester at or above ptr,
// searching upward with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_win
);

  always_comb begin
    int idx;
    winner  = '0;
    any_win = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any_win && eligible[idx]) begin
        winner[idx] = 1'b1;
        any_win     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_share_arbiter.sv
// Hands out successive values of a shared 14-step sequence to NUM_REQ requesters,
// one grant per cycle, round-robin, with pause and restart controls.
module seq_share_arbiter
  import seq_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               pause,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [3:0]         value,
  output logic               value_vld,
  output logic [3:0]         seq_idx,
  output logic               wrapped,
  output logic               busy
);

  localparam int PW = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, win_next;
  logic [3:0]         seq_idx_q, seq_idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]         value_q, value_d;
  logic               vld_q, vld_d;
  logic               wrapped_q, wrapped_d;
  logic [NUM_REQ-1:0] eligible, winner;
  logic               any_win;

  // Whoever was granted last cycle is still dropping its req; skip it once.
  assign eligible = req & ~gnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (winner),
    .any_win  (any_win)
  );

  always_comb begin
    win_next = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_next = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    seq_idx_d = seq_idx_q;
    gnt_d     = '0;
    value_d   = value_q;
    vld_d     = 1'b0;
    wrapped_d = 1'b0;
    if (pause) begin
      state_d = PAUSED;
    end else if (state_q == PAUSED) begin
      state_d = IDLE;
    end else if (any_win) begin
      state_d   = SERVE;
      gnt_d     = winner;
      value_d   = SEQ_TABLE[seq_idx_q];
      vld_d     = 1'b1;
      wrapped_d = (seq_idx_q == 4'(SEQ_LEN - 1));
      seq_idx_d = next_seq_idx(seq_idx_q);
      ptr_d     = win_next;
    end else begin
      state_d = IDLE;
    end
    // Restart takes priority over the post-grant increment.
    if (restart) seq_idx_d = 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      seq_idx_q <= 4'd0;
      gnt_q     <= '0;
      value_q   <= 4'd0;
      vld_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      seq_idx_q <= seq_idx_d;
      gnt_q     <= gnt_d;
      value_q   <= value_d;
      vld_q     <= vld_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign gnt       = gnt_q;
  assign value     = value_q;
  assign value_vld = vld_q;
  assign seq_idx   = seq_idx_q;
  assign wrapped   = wrapped_q;
  assign busy      = (state_q == SERVE);

endmodule
